// File: rtl/full_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
//   stage_ctl_t  : carry/valid pair handed from one pipeline stage to the next
//   latency()    : cycles from an accepted op to its out_valid
//   bps_divides(): true when the per-stage slice width tiles the operand width
package full_adder_pkg;

    typedef struct packed {
        logic carry;
        logic valid;
    } stage_ctl_t;

    // Input register plus one register per ripple stage.
    function automatic int unsigned latency(input int unsigned width,
                                            input int unsigned bps);
        return (width / bps) + 1;
    endfunction

    function automatic bit bps_divides(input int unsigned width,
                                       input int unsigned bps);
        return (bps != 0) && ((width % bps) == 0);
    endfunction

endpackage

// File: rtl/full_adder_pipelined_adder_slice.sv
// adder_slice: one ripple stage of the pipelined adder.
// Adds a BITS_PER_STAGE-bit slice plus the incoming carry and registers the
// partial sum, carry-out and valid. Sum/carry load only with a valid op so the
// last op's value is kept across bubbles. Synchronous active-high reset.
// Ports:
//   clk_i, rst_i : clock, synchronous reset
//   ctl_i        : carry-in and valid from the previous stage
//   a_i, b_i     : operand slice (b already inverted for subtraction)
//   ctl_o        : registered carry-out and valid
//   sum_o        : registered partial sum
module adder_slice
    import full_adder_pkg::*;
#(
    parameter int unsigned BITS_PER_STAGE = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  stage_ctl_t                ctl_i,
    input  logic [BITS_PER_STAGE-1:0] a_i,
    input  logic [BITS_PER_STAGE-1:0] b_i,
    output stage_ctl_t                ctl_o,
    output logic [BITS_PER_STAGE-1:0] sum_o
);

    logic [BITS_PER_STAGE:0]   total;
    logic [BITS_PER_STAGE-1:0] sum_q;
    stage_ctl_t                ctl_q;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{BITS_PER_STAGE{1'b0}}, ctl_i.carry};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            ctl_q <= '0;
        end else begin
            ctl_q.valid <= ctl_i.valid;
            if (ctl_i.valid) begin
                sum_q       <= total[BITS_PER_STAGE-1:0];
                ctl_q.carry <= total[BITS_PER_STAGE];
            end
        end
    end

    assign sum_o = sum_q;
    assign ctl_o = ctl_q;

endmodule

// File: rtl/full_adder_pipelined.sv
// full_adder_pipelined: WIDTH-bit ripple-carry adder/subtractor pipelined one
// slice of BITS_PER_STAGE bits per clock. Throughput one op per cycle, latency
// WIDTH/BITS_PER_STAGE + 1 cycles. Results hold between valid outputs.
// Optional feature macro: FA_OVERFLOW_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_valid, a, b   : operand strobe and operands
//   cin              : carry-in (ignored for subtraction)
//   sub              : 1 = a - b, 0 = a + b + cin
//   out_valid, sum   : result strobe and result
//   cout             : carry-out / not-borrow
//   ovf              : signed overflow (FA_OVERFLOW_EN only)
module full_adder_pipelined
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned BPS     = BITS_PER_STAGE;
    localparam int unsigned NSTAGE  = WIDTH / BPS;
    localparam int unsigned LATENCY = latency(WIDTH, BPS);

    if (WIDTH < 1 || !bps_divides(WIDTH, BPS) || LATENCY != NSTAGE + 1) begin : g_bad_cfg
        $error("full_adder_pipelined: BITS_PER_STAGE must divide WIDTH");
    end

    // Input stage: subtraction becomes a + ~b + 1.
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_b_q;
    stage_ctl_t       in_ctl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_a_q   <= '0;
            in_b_q   <= '0;
            in_ctl_q <= '0;
        end else begin
            in_ctl_q.valid <= in_valid;
            if (in_valid) begin
                in_a_q         <= a;
                in_b_q         <= sub ? ~b : b;
                in_ctl_q.carry <= sub | cin;
            end
        end
    end

    // stage_ctl[k] feeds stage k; stage_ctl[NSTAGE] is the final carry/valid.
    stage_ctl_t stage_ctl [NSTAGE+1];
    assign stage_ctl[0] = in_ctl_q;

`ifdef FA_OVERFLOW_EN
    logic msb_carry_d;
    logic msb_carry_q;
`endif

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [BPS-1:0] op_a;
        logic [BPS-1:0] op_b;
        logic [BPS-1:0] slice_sum;

        // Skew: stage k consumes its operand slice k cycles after the input stage.
        if (k == 0) begin : g_direct
            assign op_a = in_a_q[BPS-1:0];
            assign op_b = in_b_q[BPS-1:0];
        end else begin : g_skew
            logic [BPS-1:0] skew_a_q [k];
            logic [BPS-1:0] skew_b_q [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        skew_a_q[j] <= '0;
                        skew_b_q[j] <= '0;
                    end
                end else begin
                    skew_a_q[0] <= in_a_q[k*BPS +: BPS];
                    skew_b_q[0] <= in_b_q[k*BPS +: BPS];
                    for (int j = 1; j < k; j++) begin
                        skew_a_q[j] <= skew_a_q[j-1];
                        skew_b_q[j] <= skew_b_q[j-1];
                    end
                end
            end

            assign op_a = skew_a_q[k-1];
            assign op_b = skew_b_q[k-1];
        end

        adder_slice #(
            .BITS_PER_STAGE(BPS)
        ) u_slice (
            .clk_i (clk),
            .rst_i (rst),
            .ctl_i (stage_ctl[k]),
            .a_i   (op_a),
            .b_i   (op_b),
            .ctl_o (stage_ctl[k+1]),
            .sum_o (slice_sum)
        );

        // Deskew: lower slices wait for the last stage. Each register loads only
        // alongside a valid op, so sum holds through bubbles.
        if (k == NSTAGE - 1) begin : g_last
            assign sum[k*BPS +: BPS] = slice_sum;

`ifdef FA_OVERFLOW_EN
            // Carry into the MSB = MSB sum bit with the MSB operand bits removed.
            assign msb_carry_d = op_a[BPS-1] ^ op_b[BPS-1]
                               ^ 1'((op_a + op_b + BPS'(stage_ctl[k].carry)) >> (BPS - 1));
`endif
        end else begin : g_deskew
            logic [BPS-1:0] deskew_q [NSTAGE-1-k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < NSTAGE - 1 - k; j++) begin
                        deskew_q[j] <= '0;
                    end
                end else begin
                    if (stage_ctl[k+1].valid) begin
                        deskew_q[0] <= slice_sum;
                    end
                    for (int j = 1; j < NSTAGE - 1 - k; j++) begin
                        if (stage_ctl[k+1+j].valid) begin
                            deskew_q[j] <= deskew_q[j-1];
                        end
                    end
                end
            end

            assign sum[k*BPS +: BPS] = deskew_q[NSTAGE-2-k];
        end
    end

    assign out_valid = stage_ctl[NSTAGE].valid;
    assign cout      = stage_ctl[NSTAGE].carry;

`ifdef FA_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_carry_q <= 1'b0;
        end else if (stage_ctl[NSTAGE-1].valid) begin
            msb_carry_q <= msb_carry_d;
        end
    end

    assign ovf = msb_carry_q ^ stage_ctl[NSTAGE].carry;
`endif

endmodule

// File: tb/tb_full_adder_pipelined.sv
// Directed bench for full_adder_pipelined: three instances (8-bit/1-bit slices,
// 8-bit/4-bit slices, 1-bit/1-bit slice) driven from one linear sequence.
// Cycle n is the interval just after rising edge n; inputs and samples sit #1
// after the edge.
module tb_full_adder_pipelined;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=8, BPS=1 (latency 9)
    logic       da_in_valid = 1'b0, da_cin = 1'b0, da_sub = 1'b0;
    logic [7:0] da_a = '0, da_b = '0;
    logic       da_out_valid, da_cout;
    logic [7:0] da_sum;
    // Instance B: WIDTH=8, BPS=4 (latency 3)
    logic       db_in_valid = 1'b0, db_cin = 1'b0, db_sub = 1'b0;
    logic [7:0] db_a = '0, db_b = '0;
    logic       db_out_valid, db_cout;
    logic [7:0] db_sum;
    // Instance C: WIDTH=1, BPS=1 (latency 2)
    logic       dc_in_valid = 1'b0, dc_cin = 1'b0, dc_sub = 1'b0;
    logic [0:0] dc_a = '0, dc_b = '0;
    logic       dc_out_valid, dc_cout;
    logic [0:0] dc_sum;
`ifdef FA_OVERFLOW_EN
    logic da_ovf, db_ovf, dc_ovf;
`endif

    full_adder_pipelined #(.WIDTH(8), .BITS_PER_STAGE(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(da_in_valid), .a(da_a), .b(da_b), .cin(da_cin),
        .sub(da_sub), .out_valid(da_out_valid), .sum(da_sum), .cout(da_cout)
`ifdef FA_OVERFLOW_EN
        , .ovf(da_ovf)
`endif
    );

    full_adder_pipelined #(.WIDTH(8), .BITS_PER_STAGE(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(db_in_valid), .a(db_a), .b(db_b), .cin(db_cin),
        .sub(db_sub), .out_valid(db_out_valid), .sum(db_sum), .cout(db_cout)
`ifdef FA_OVERFLOW_EN
        , .ovf(db_ovf)
`endif
    );

    full_adder_pipelined #(.WIDTH(1), .BITS_PER_STAGE(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(dc_in_valid), .a(dc_a), .b(dc_b), .cin(dc_cin),
        .sub(dc_sub), .out_valid(dc_out_valid), .sum(dc_sum), .cout(dc_cout)
`ifdef FA_OVERFLOW_EN
        , .ovf(dc_ovf)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [7:0] x, input logic [7:0] y,
                           input logic c, input logic s);
        da_in_valid = v;
        da_a        = x;
        da_b        = y;
        da_cin      = c;
        da_sub      = s;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] x, input logic [7:0] y);
        db_in_valid = v;
        db_a        = x;
        db_b        = y;
    endtask

    // 1-bit full-adder truth table indexed by {a, b, cin}
    logic [7:0] fa_sum_tbl  = 8'b1001_0110;
    logic [7:0] fa_cout_tbl = 8'b1110_1000;

    initial begin
        // Reset state
        tick(2);
        check("rst_a_valid", {7'b0, da_out_valid}, 8'h00);
        check("rst_a_sum", da_sum, 8'h00);
        check("rst_a_cout", {7'b0, da_cout}, 8'h00);
        check("rst_b_valid", {7'b0, db_out_valid}, 8'h00);
        check("rst_c_valid", {7'b0, dc_out_valid}, 8'h00);
        rst = 1'b0;
        tick(1);

        // A: wrap-around 0xFF + 0x01
        drive_a(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(7);
        check("wrap_c8_valid", {7'b0, da_out_valid}, 8'h00);
        tick(1);
        check("wrap_c9_valid", {7'b0, da_out_valid}, 8'h01);
        check("wrap_c9_sum", da_sum, 8'h00);
        check("wrap_c9_cout", {7'b0, da_cout}, 8'h01);
        tick(1);
        check("wrap_c10_valid", {7'b0, da_out_valid}, 8'h00);
        check("wrap_c10_cout_hold", {7'b0, da_cout}, 8'h01);

        // A: 0x05 - 0x07 with cin=1 ignored
        drive_a(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
        tick(1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(7);
        check("sub_c8_valid", {7'b0, da_out_valid}, 8'h00);
        tick(1);
        check("sub_c9_valid", {7'b0, da_out_valid}, 8'h01);
        check("sub_c9_sum", da_sum, 8'hFE);
        check("sub_c9_cout", {7'b0, da_cout}, 8'h00);

        // A: back-to-back with one bubble (its operands must be ignored)
        drive_a(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b0, 8'hAA, 8'h55, 1'b1, 1'b0);
        tick(1);
        drive_a(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(5);
        check("b2b_c9_valid", {7'b0, da_out_valid}, 8'h01);
        check("b2b_c9_sum", da_sum, 8'h03);
        check("b2b_c9_cout", {7'b0, da_cout}, 8'h00);
        tick(1);
        check("b2b_c10_valid", {7'b0, da_out_valid}, 8'h01);
        check("b2b_c10_sum", da_sum, 8'h07);
        tick(1);
        check("b2b_c11_valid", {7'b0, da_out_valid}, 8'h00);
        check("b2b_c11_sum_hold", da_sum, 8'h07);
        tick(1);
        check("b2b_c12_valid", {7'b0, da_out_valid}, 8'h01);
        check("b2b_c12_sum", da_sum, 8'h00);
        check("b2b_c12_cout", {7'b0, da_cout}, 8'h01);

        // A: reset while four ops are in flight
        drive_a(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
        tick(1);
        drive_a(1'b1, 8'h9A, 8'hBC, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(1);
        rst = 1'b1;
        drive_a(1'b1, 8'h11, 8'h11, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        check("rst_c6_valid", {7'b0, da_out_valid}, 8'h00);
        check("rst_c6_sum", da_sum, 8'h00);
        check("rst_c6_cout", {7'b0, da_cout}, 8'h00);
        drive_a(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        tick(1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_c7_valid", {7'b0, da_out_valid}, 8'h00);
        for (int c = 8; c <= 14; c++) begin
            tick(1);
            check($sformatf("rst_c%0d_valid", c), {7'b0, da_out_valid}, 8'h00);
        end
        tick(1);
        check("rst_c15_valid", {7'b0, da_out_valid}, 8'h01);
        check("rst_c15_sum", da_sum, 8'h30);
        check("rst_c15_cout", {7'b0, da_cout}, 8'h00);

        // B: 4-bit slices, latency 3
        drive_b(1'b1, 8'h7F, 8'h01);
        tick(1);
        drive_b(1'b1, 8'h80, 8'h80);
        tick(1);
        drive_b(1'b0, 8'h00, 8'h00);
        check("bps4_c2_valid", {7'b0, db_out_valid}, 8'h00);
        tick(1);
        check("bps4_c3_valid", {7'b0, db_out_valid}, 8'h01);
        check("bps4_c3_sum", db_sum, 8'h80);
        check("bps4_c3_cout", {7'b0, db_cout}, 8'h00);
`ifdef FA_OVERFLOW_EN
        check("bps4_c3_ovf", {7'b0, db_ovf}, 8'h01);
`endif
        tick(1);
        check("bps4_c4_valid", {7'b0, db_out_valid}, 8'h01);
        check("bps4_c4_sum", db_sum, 8'h00);
        check("bps4_c4_cout", {7'b0, db_cout}, 8'h01);
`ifdef FA_OVERFLOW_EN
        check("bps4_c4_ovf", {7'b0, db_ovf}, 8'h01);
`endif
        tick(1);
        check("bps4_c5_valid", {7'b0, db_out_valid}, 8'h00);
        check("bps4_c5_cout_hold", {7'b0, db_cout}, 8'h01);

        // C: 1-bit exhaustive, ops back-to-back in cycles 0..7, results in 2..9
        {dc_a, dc_b, dc_cin} = 3'd0;
        dc_in_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            if (c < 8) begin
                {dc_a, dc_b, dc_cin} = 3'(c);
            end else begin
                dc_in_valid = 1'b0;
            end
            if (c >= 2) begin
                check($sformatf("fa1_op%0d_valid", c - 2), {7'b0, dc_out_valid}, 8'h01);
                check($sformatf("fa1_op%0d_sum", c - 2), {7'b0, dc_sum},
                      {7'b0, fa_sum_tbl[c-2]});
                check($sformatf("fa1_op%0d_cout", c - 2), {7'b0, dc_cout},
                      {7'b0, fa_cout_tbl[c-2]});
            end else begin
                check("fa1_c1_valid", {7'b0, dc_out_valid}, 8'h00);
            end
        end
        tick(1);
        check("fa1_c10_valid", {7'b0, dc_out_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
